// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the CNN accelerator buffer blocks: default BRAM
// geometry and the ping-pong bank-select type.
package cnn_acc_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W_DEF = 64;

   typedef enum logic {
      BANK_A = 1'b0,
      BANK_B = 1'b1
   } bank_sel_t;

   // Two banks only, so advancing the select wraps B back to A.
   function automatic bank_sel_t bank_toggle(input bank_sel_t sel);
      return (sel == BANK_A) ? BANK_B : BANK_A;
   endfunction

endpackage

// File: rtl/bank_port_mux.sv
// Steers one BRAM bank port to either the producer (write side) or the
// consumer (read side); purely combinational, no added latency.
module bank_port_mux #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 64
) (
   input  logic              prod_own,
   input  logic              prod_we,
   input  logic [ADDR_W-1:0] prod_addr,
   input  logic [DATA_W-1:0] prod_din,
   input  logic [ADDR_W-1:0] cons_addr,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din
);

   always_comb begin
      we   = prod_own & prod_we;
      addr = prod_own ? prod_addr : cons_addr;
      din  = prod_own ? prod_din  : '0;
   end

endmodule

// File: rtl/pingpong_bram_ctrl.sv
// Ping-pong controller for two external single-port BRAM banks (1-cycle read).
// Define PINGPONG_ERR_CHK_EN to enable the sticky protocol-error flag.
module pingpong_bram_ctrl
   import cnn_acc_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prod_we,
   input  logic [ADDR_W-1:0] prod_addr,
   input  logic [DATA_W-1:0] prod_din,
   input  logic              prod_done,
   output logic              prod_ready,
   input  logic              cons_re,
   input  logic [ADDR_W-1:0] cons_addr,
   input  logic              cons_done,
   output logic              cons_valid,
   output logic [DATA_W-1:0] cons_dout,
   output logic              cons_dout_vld,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] din_a,
   input  logic [DATA_W-1:0] dout_a,
   output logic              we_b,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] din_b,
   input  logic [DATA_W-1:0] dout_b,
   output logic [1:0]        occ,
   output logic              err
);

   bank_sel_t  wr_sel, wr_sel_n;
   bank_sel_t  rd_sel, rd_sel_n;
   bank_sel_t  rd_q;
   logic [1:0] full, full_n;
   logic       vld_q;
   logic       prod_acc, cons_acc, rd_acc;
   logic       own_a, own_b;
   logic       prod_we_g;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sel <= BANK_A;
         rd_sel <= BANK_A;
         full   <= '0;
         rd_q   <= BANK_A;
         vld_q  <= 1'b0;
      end else begin
         wr_sel <= wr_sel_n;
         rd_sel <= rd_sel_n;
         full   <= full_n;
         vld_q  <= rd_acc;
         if (rd_acc)
            rd_q <= rd_sel;
      end
   end

   // Next state: producer and consumer never act on the same bank, since
   // prod_ready and cons_valid cannot both hold when wr_sel == rd_sel.
   always_comb begin
      full_n   = full;
      wr_sel_n = wr_sel;
      rd_sel_n = rd_sel;
      if (prod_acc) begin
         full_n[wr_sel] = 1'b1;
         wr_sel_n       = bank_toggle(wr_sel);
      end
      if (cons_acc) begin
         full_n[rd_sel] = 1'b0;
         rd_sel_n       = bank_toggle(rd_sel);
      end
   end

   // Outputs
   always_comb begin
      prod_ready    = !full[wr_sel];
      cons_valid    = full[rd_sel];
      occ           = {1'b0, full[0]} + {1'b0, full[1]};
      prod_acc      = prod_done & prod_ready;
      cons_acc      = cons_done & cons_valid;
      rd_acc        = cons_re & cons_valid;
      own_a         = prod_ready & (wr_sel == BANK_A);
      own_b         = prod_ready & (wr_sel == BANK_B);
      cons_dout_vld = vld_q;
      cons_dout     = (rd_q == BANK_B) ? dout_b : dout_a;
   end

   // Write strobes must drop while reset is held even though the reset
   // state hands bank A to the producer.
   assign prod_we_g = prod_we & rst_n;

   bank_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux_a (
      .prod_own  (own_a),
      .prod_we   (prod_we_g),
      .prod_addr (prod_addr),
      .prod_din  (prod_din),
      .cons_addr (cons_addr),
      .we        (we_a),
      .addr      (addr_a),
      .din       (din_a)
   );

   bank_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux_b (
      .prod_own  (own_b),
      .prod_we   (prod_we_g),
      .prod_addr (prod_addr),
      .prod_din  (prod_din),
      .cons_addr (cons_addr),
      .we        (we_b),
      .addr      (addr_b),
      .din       (din_b)
   );

`ifdef PINGPONG_ERR_CHK_EN
   logic err_q;
   logic viol;

   assign viol = ((prod_we | prod_done) & !prod_ready) |
                 ((cons_re | cons_done) & !cons_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (viol)
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_bram_ctrl.sv
// Table-driven bench for pingpong_bram_ctrl with behavioural BRAM banks and a
// read-data scoreboard; honours PINGPONG_ERR_CHK_EN for the err expectation.
module tb_pingpong_bram_ctrl;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 64;
`ifdef PINGPONG_ERR_CHK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prod_we, prod_done, cons_re, cons_done;
   logic [AW-1:0] prod_addr, cons_addr;
   logic [DW-1:0] prod_din;
   logic          prod_ready, cons_valid, cons_dout_vld, err;
   logic [DW-1:0] cons_dout;
   logic          we_a, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] din_a, din_b, dout_a, dout_b;
   logic [1:0]    occ;

   logic [DW-1:0] mem_a [1<<AW];
   logic [DW-1:0] mem_b [1<<AW];

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] sbq [$];

   always #5 clk = ~clk;

   // Behavioural single-port BRAMs, read-first, one-cycle read latency
   always @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= din_a;
      dout_a <= mem_a[addr_a];
      if (we_b) mem_b[addr_b] <= din_b;
      dout_b <= mem_b[addr_b];
   end

   pingpong_bram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .prod_we(prod_we), .prod_addr(prod_addr), .prod_din(prod_din),
      .prod_done(prod_done), .prod_ready(prod_ready),
      .cons_re(cons_re), .cons_addr(cons_addr), .cons_done(cons_done),
      .cons_valid(cons_valid), .cons_dout(cons_dout), .cons_dout_vld(cons_dout_vld),
      .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
      .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b),
      .occ(occ), .err(err)
   );

   typedef struct {
      logic          pwe;
      logic [AW-1:0] paddr;
      logic [DW-1:0] pdin;
      logic          pdone;
      logic          cre;
      logic [AW-1:0] caddr;
      logic          cdone;
      logic          e_ready;
      logic          e_valid;
      logic [1:0]    e_occ;
      logic          e_wea;
      logic          e_web;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t rows [$];

   function automatic vec_t mk(logic pwe, int paddr, logic [DW-1:0] pdin, logic pdone,
                               logic cre, int caddr, logic cdone,
                               logic er, logic ev, int eo, logic ewa, logic ewb,
                               logic [DW-1:0] erd);
      vec_t v;
      v.pwe = pwe; v.paddr = AW'(paddr); v.pdin = pdin; v.pdone = pdone;
      v.cre = cre; v.caddr = AW'(caddr); v.cdone = cdone;
      v.e_ready = er; v.e_valid = ev; v.e_occ = 2'(eo);
      v.e_wea = ewa; v.e_web = ewb; v.e_rdata = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      prod_we = 0; prod_addr = '0; prod_din = '0; prod_done = 0;
      cons_re = 0; cons_addr = '0; cons_done = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".prod_ready"}, 64'(prod_ready), 64'd1);
      chk({tag, ".cons_valid"}, 64'(cons_valid), 64'd0);
      chk({tag, ".occ"}, 64'(occ), 64'd0);
      chk({tag, ".we_a"}, 64'(we_a), 64'd0);
      chk({tag, ".we_b"}, 64'(we_b), 64'd0);
      chk({tag, ".err"}, 64'(err), 64'd0);
      chk({tag, ".vld"}, 64'(cons_dout_vld), 64'd0);
   endtask

   // One clock of stimulus: check combinational outputs before the edge, the
   // registered read result just after it.
   task automatic apply(input string tag, input vec_t v);
      logic exp_vld;
      prod_we = v.pwe; prod_addr = v.paddr; prod_din = v.pdin; prod_done = v.pdone;
      cons_re = v.cre; cons_addr = v.caddr; cons_done = v.cdone;
      exp_vld = v.cre & v.e_valid;
      if (exp_vld) sbq.push_back(v.e_rdata);
      #1;
      chk({tag, ".prod_ready"}, 64'(prod_ready), 64'(v.e_ready));
      chk({tag, ".cons_valid"}, 64'(cons_valid), 64'(v.e_valid));
      chk({tag, ".occ"}, 64'(occ), 64'(v.e_occ));
      chk({tag, ".we_a"}, 64'(we_a), 64'(v.e_wea));
      chk({tag, ".we_b"}, 64'(we_b), 64'(v.e_web));
      @(posedge clk);
      #1;
      chk({tag, ".vld"}, 64'(cons_dout_vld), 64'(exp_vld));
      if (cons_dout_vld && sbq.size() > 0)
         chk({tag, ".dout"}, cons_dout, sbq.pop_front());
   endtask

   task automatic do_reset(input string tag);
      rst_n = 0;
      sbq.delete();
      #1;
      chk_reset(tag);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      drive_idle();
      rst_n = 0;
      #12;
      chk_reset("rst0");
      @(posedge clk);
      #1;
      rst_n = 1;

      //        pwe addr data      pd  cre addr cd   rdy val occ wa wb  rdata
      rows.push_back(mk(1, 0, 64'h11, 0,  0, 0, 0,   1, 0, 0,  1, 0, 0));
      rows.push_back(mk(1, 1, 64'h22, 0,  0, 0, 0,   1, 0, 0,  1, 0, 0));
      rows.push_back(mk(1, 2, 64'h33, 0,  0, 0, 0,   1, 0, 0,  1, 0, 0));
      rows.push_back(mk(1, 3, 64'h44, 1,  0, 0, 0,   1, 0, 0,  1, 0, 0));
      rows.push_back(mk(0, 0, 64'h00, 0,  0, 0, 0,   1, 1, 1,  0, 0, 0));
      rows.push_back(mk(0, 0, 64'h00, 0,  1, 2, 0,   1, 1, 1,  0, 0, 64'h33));
      rows.push_back(mk(1, 0, 64'h55, 0,  1, 0, 0,   1, 1, 1,  0, 1, 64'h11));
      rows.push_back(mk(1, 1, 64'h66, 1,  0, 0, 0,   1, 1, 1,  0, 1, 0));
      rows.push_back(mk(1, 0, 64'h99, 0,  0, 0, 0,   0, 1, 2,  0, 0, 0));
      rows.push_back(mk(0, 0, 64'h00, 0,  1, 1, 1,   0, 1, 2,  0, 0, 64'h22));
      rows.push_back(mk(0, 0, 64'h00, 0,  0, 0, 0,   1, 1, 1,  0, 0, 0));
      rows.push_back(mk(1, 0, 64'h77, 1,  1, 1, 1,   1, 1, 1,  1, 0, 64'h66));
      rows.push_back(mk(0, 0, 64'h00, 0,  1, 0, 0,   1, 1, 1,  0, 0, 64'h77));
      rows.push_back(mk(1, 2, 64'hAA, 0,  0, 0, 0,   1, 1, 1,  0, 1, 0));
      rows.push_back(mk(0, 0, 64'h00, 0,  0, 0, 1,   1, 1, 1,  0, 1, 0));
      rows.push_back(mk(0, 0, 64'h00, 0,  0, 0, 0,   1, 0, 0,  0, 0, 0));
      // row 14 holds pwe low, so we_b there must be 0
      rows[14].e_web = 0;

      for (int unsigned i = 0; i < rows.size(); i++)
         apply($sformatf("row%0d", i), rows[i]);

      // Read and done with nothing available: no data, err only when checked
      do_reset("rst1");
      apply("empty_rd", mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
      chk("empty_rd.err", 64'(err), 64'(ERR_EN));
      drive_idle();

      // Fill both banks, then reset with a read in flight and a write pending
      do_reset("rst2");
      apply("fillA", mk(1, 5, 64'hDEAD, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      apply("fillB", mk(1, 5, 64'hBEEF, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0));
      apply("full2", mk(1, 6, 64'h1234, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
      prod_we = 1; prod_addr = AW'(6); prod_din = 64'h1234;
      cons_re = 1; cons_addr = AW'(5);
      #1;
      rst_n = 0;
      sbq.delete();
      #1;
      chk_reset("midrst");
      @(posedge clk);
      #1;
      chk_reset("midrst_edge");
      rst_n = 1;
      drive_idle();

      // BRAM contents survive reset: mark A full without writing, read it back
      apply("keepA", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      apply("keepA_rd", mk(0, 0, 0, 0, 1, 5, 0, 1, 1, 1, 0, 0, 64'hDEAD));
      drive_idle();
      @(posedge clk);
      #1;
      chk("tail.vld", 64'(cons_dout_vld), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
